// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | pipe_hazard_ctrl : stall/flush sequencer for the 5-stage pipeline (load-use, branch, |
// |                    dmem wait, ack timeout). Optional perf counters: PIPE_PERF_CNT_EN |
// | Revision: 1.0                                                                        |
// +--------------------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
   parameter int ACK_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_flush,
   output logic             exmem_we,
   output logic             memwb_flush,
   output logic             mem_err,
`ifdef PIPE_PERF_CNT_EN
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events,
`endif
   output logic [1:0]       fsm_state
);

   localparam logic [1:0] ST_RUN      = 2'b00;
   localparam logic [1:0] ST_MEM_WAIT = 2'b01;
   localparam logic [1:0] ST_ERR      = 2'b10;

   if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
      $error("pipe_hazard_ctrl: ACK_TIMEOUT must be 1..255 and CNT_W >= 1");
   end

   logic [1:0] state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       mem_err_q, mem_err_d;
   logic       load_use;
   logic       freeze;

   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   // An ack in MEM_WAIT is the release cycle, so it never freezes; ERR ignores ack.
   always_comb begin
      freeze = 1'b1;
      case (state_q)
         ST_RUN:      freeze = mem_req && !mem_ack;
         ST_MEM_WAIT: freeze = !mem_ack;
         default:     freeze = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= 8'd0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (mem_req && !mem_ack) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = 8'd1;
            end else begin
               wait_cnt_d = 8'd0;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ack) begin
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q == 8'(ACK_TIMEOUT)) begin
               state_d = ST_ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: state_d = ST_ERR;
      endcase
      mem_err_d = mem_err_q || (state_d == ST_ERR);
   end

   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      if (!rst) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_we     = 1'b0;
         exmem_we    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
      end else if (freeze) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_we     = 1'b0;
         exmem_we    = 1'b0;
         memwb_flush = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   assign fsm_state = rst ? state_q : ST_RUN;
   assign mem_err   = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_events_q, flush_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q + CNT_W'(!pc_we);
      flush_events_d = flush_events_q + CNT_W'(ifid_flush);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// Testbench for pipe_hazard_ctrl: rule-level model compared every cycle plus directed
// literal checks. Perf-counter checks are active when PIPE_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;
   localparam int T = 4;

   localparam logic [6:0] C_RST  = 7'b0010101;
   localparam logic [6:0] C_RUN  = 7'b1101010;
   localparam logic [6:0] C_FRZ  = 7'b0000001;
   localparam logic [6:0] C_BR   = 7'b1111110;
   localparam logic [6:0] C_LU   = 7'b0001110;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
   logic       ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
   logic       pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush;
   logic       mem_err;
   logic [1:0] fsm_state;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_events;
`endif

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.ACK_TIMEOUT(T), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ack(mem_ack), .pc_we(pc_we), .ifid_we(ifid_we),
      .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_flush(idex_flush),
      .exmem_we(exmem_we), .memwb_flush(memwb_flush), .mem_err(mem_err),
`ifdef PIPE_PERF_CNT_EN
      .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
      .fsm_state(fsm_state)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] dut_ctrl();
      return {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush};
   endfunction

   // Model: waiting-on-memory flag, count of wait cycles, dead flag, perf tallies.
   bit          m_busy = 0, m_dead = 0;
   int          m_waited = 0;
   logic [31:0] m_stall = '0, m_flush = '0;
   logic        hazard;
   logic [6:0]  exp_ctrl;
   logic [1:0]  exp_fsm;

   assign hazard = ex_mem_read && ex_rd != 5'd0 &&
                   ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));

   always_comb begin
      exp_ctrl = C_RUN;
      if (!rst)                                       exp_ctrl = C_RST;
      else if (m_dead || ((m_busy || mem_req) && !mem_ack)) exp_ctrl = C_FRZ;
      else if (ex_branch_taken)                       exp_ctrl = C_BR;
      else if (hazard)                                exp_ctrl = C_LU;
      exp_fsm = !rst ? 2'd0 : m_dead ? 2'd2 : m_busy ? 2'd1 : 2'd0;
   end

   always @(posedge clk) begin
      if (!rst) begin
         m_busy = 0; m_dead = 0; m_waited = 0; m_stall = '0; m_flush = '0;
      end else begin
         if (!exp_ctrl[6]) m_stall++;
         if (exp_ctrl[4])  m_flush++;
         if (m_dead) begin
         end else if (!m_busy) begin
            if (mem_req && !mem_ack) begin m_busy = 1; m_waited = 1; end
         end else if (mem_ack) begin
            m_busy = 0; m_waited = 0;
         end else if (m_waited == T) begin
            m_dead = 1;
         end else begin
            m_waited++;
         end
      end
   end

   always @(negedge clk) begin
      check("model_ctrl", dut_ctrl(), exp_ctrl);
      check("model_fsm", fsm_state, exp_fsm);
      check("model_err", mem_err, m_dead);
`ifdef PIPE_PERF_CNT_EN
      check("model_stall", stall_cycles, m_stall);
      check("model_flush", flush_events, m_flush);
`endif
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ack = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk); check("rst_ctrl", dut_ctrl(), C_RST); check("rst_fsm", fsm_state, 2'd0);
      next(); rst = 1;
      @(negedge clk); check("idle", dut_ctrl(), C_RUN);

      next(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
      @(negedge clk); check("lu_rs1", dut_ctrl(), C_LU);
      next(); ex_mem_read = 0; ex_rd = 0;
      @(negedge clk); check("lu_bubble", dut_ctrl(), C_RUN);
      next(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
      @(negedge clk); check("lu_x0", dut_ctrl(), C_RUN);
      next(); ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1; id_uses_rs1 = 0; id_rs1 = 7;
      @(negedge clk); check("lu_rs2", dut_ctrl(), C_LU);
      next(); id_uses_rs2 = 0;
      @(negedge clk); check("lu_unused", dut_ctrl(), C_RUN);
      next(); ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; ex_branch_taken = 1;
      @(negedge clk); check("br_over_lu", dut_ctrl(), C_BR);
      next(); clear_in();

      // dmem wait: three frozen cycles, then the release cycle
      next(); mem_req = 1;
      @(negedge clk); check("mw_frz0", dut_ctrl(), C_FRZ); check("mw_fsm0", fsm_state, 2'd0);
      for (int i = 0; i < 2; i++) begin
         next();
         @(negedge clk); check("mw_frz", dut_ctrl(), C_FRZ); check("mw_fsm", fsm_state, 2'd1);
      end
      next(); mem_ack = 1;
      @(negedge clk); check("mw_rel", dut_ctrl(), C_RUN); check("mw_rel_fsm", fsm_state, 2'd1);
      next(); clear_in();
      @(negedge clk); check("mw_back", fsm_state, 2'd0);

      next(); mem_req = 1; mem_ack = 1;
      @(negedge clk); check("mw_zero", dut_ctrl(), C_RUN);
      next(); clear_in();
      @(negedge clk); check("mw_zero_fsm", fsm_state, 2'd0);

      next(); mem_req = 1;
      next(); mem_ack = 1; ex_branch_taken = 1;
      @(negedge clk); check("rel_branch", dut_ctrl(), C_BR);
      next(); clear_in();

      // ack arriving on the last allowed wait cycle wins
      next(); mem_req = 1;
      repeat (4) next();
      mem_ack = 1;
      @(negedge clk); check("ack_edge", dut_ctrl(), C_RUN); check("ack_edge_fsm", fsm_state, 2'd1);
      next(); clear_in();
      @(negedge clk); check("ack_edge_run", fsm_state, 2'd0); check("ack_edge_err", mem_err, 1'b0);

      // timeout
      next(); mem_req = 1;
      repeat (4) next();
      @(negedge clk); check("to_wait", fsm_state, 2'd1); check("to_noerr", mem_err, 1'b0);
      next();
      @(negedge clk); check("to_fsm", fsm_state, 2'd2); check("to_err", mem_err, 1'b1);
      next(); mem_ack = 1;
      @(negedge clk); check("err_ack", dut_ctrl(), C_FRZ); check("err_hold", mem_err, 1'b1);
      next(); clear_in(); rst = 0;
      next();
      @(negedge clk); check("rst_err", mem_err, 1'b0); check("rst_fsm2", fsm_state, 2'd0);
      next(); rst = 1;

`ifdef PIPE_PERF_CNT_EN
      next(); mem_req = 1;
      next();
      next();
      next(); mem_ack = 1;
      next(); clear_in(); ex_branch_taken = 1;
      next(); clear_in();
      @(negedge clk);
      check("perf_stall", stall_cycles, 32'd3);
      check("perf_flush", flush_events, 32'd1);
`endif
      next();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
